// File: rtl/decode_writeback.sv
// Y86-64 decode/write-back stage.
// Register IDs, operand forwarding, register file commit.
module decode_writeback #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RRSP  = 4'h4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB,
  input  logic [3:0]  dbg_addr,
  output logic [63:0] dbg_data
);

  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [63:0] rf_q [15];
  logic [63:0] rf_d [15];

  // Function code does not affect register selection.
  logic unused_ifun;
  assign unused_ifun = ^D_ifun;

  // Register file read; ID F is not storage and reads as zero.
  function automatic logic [63:0] rf_rd(
    input logic [63:0] rf [15],
    input logic [3:0]  a
  );
    if (a == RNONE) return 64'd0;
    return rf[a];
  endfunction

  // Source/destination ID decode; unknown icodes select no register.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_RRMOV: begin
        d_srcA = D_rA;
        d_dstE = D_rB;
      end
      I_IRMOV: d_dstE = D_rB;
      I_RMMOV: begin
        d_srcA = D_rA;
        d_srcB = D_rB;
      end
      I_MRMOV: begin
        d_srcB = D_rB;
        d_dstM = D_rA;
      end
      I_OPQ: begin
        d_srcA = D_rA;
        d_srcB = D_rB;
        d_dstE = D_rB;
      end
      I_CALL: begin
        d_srcB = RRSP;
        d_dstE = RRSP;
      end
      I_RET: begin
        d_srcA = RRSP;
        d_srcB = RRSP;
        d_dstE = RRSP;
      end
      I_PUSH: begin
        d_srcA = D_rA;
        d_srcB = RRSP;
        d_dstE = RRSP;
      end
      I_POP: begin
        d_srcA = RRSP;
        d_srcB = RRSP;
        d_dstE = RRSP;
        d_dstM = D_rA;
      end
      default: ;
    endcase
  end

  // Operand A: valP for jump/call, else youngest matching producer.
  always_comb begin
    d_valA = 64'd0;
    if (D_icode == I_JXX || D_icode == I_CALL)
      d_valA = D_valP;
    else if (d_srcA == RNONE)
      d_valA = 64'd0;
    else if (d_srcA == e_dstE)
      d_valA = e_valE;
    else if (d_srcA == M_dstM)
      d_valA = m_valM;
    else if (d_srcA == M_dstE)
      d_valA = M_valE;
    else if (d_srcA == W_dstM)
      d_valA = W_valM;
    else if (d_srcA == W_dstE)
      d_valA = W_valE;
    else
      d_valA = rf_rd(rf_q, d_srcA);
  end

  // Operand B: youngest matching producer, else register file.
  always_comb begin
    d_valB = 64'd0;
    if (d_srcB == RNONE)
      d_valB = 64'd0;
    else if (d_srcB == e_dstE)
      d_valB = e_valE;
    else if (d_srcB == M_dstM)
      d_valB = m_valM;
    else if (d_srcB == M_dstE)
      d_valB = M_valE;
    else if (d_srcB == W_dstM)
      d_valB = W_valM;
    else if (d_srcB == W_dstE)
      d_valB = W_valE;
    else
      d_valB = rf_rd(rf_q, d_srcB);
  end

  // Debug read port.
  always_comb begin
    dbg_data = rf_rd(rf_q, dbg_addr);
  end

  // Next register file state; the M write lands last so popq %rsp
  // leaves the loaded value in %rsp.
  always_comb begin
    rf_d = rf_q;
    if (W_dstE != RNONE)
      rf_d[W_dstE] = W_valE;
    if (W_dstM != RNONE)
      rf_d[W_dstM] = W_valM;
  end

  // Commit write-back; reset clears every register.
  always_ff @(posedge clk) begin
    if (reset)
      rf_q <= '{default: 64'd0};
    else
      rf_q <= rf_d;
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback.
// Vector table plus write-back sequences, checked via a scoreboard.
module tb_decode_writeback;

  localparam logic [3:0] F = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_writeback dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [3:0]  sa, sb, de, dm;
    logic [63:0] va, vb;
  } exp_t;

  typedef struct {
    logic [3:0]  icode, rA, rB;
    logic [63:0] valP;
    logic [3:0]  ed, mm, me, wm, we;
    exp_t        x;
  } vec_t;

  exp_t sb_q[$];

  function automatic vec_t mk(
    input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
    input logic [63:0] vp,
    input logic [3:0] ed, input logic [3:0] mm, input logic [3:0] me,
    input logic [3:0] wm, input logic [3:0] we,
    input logic [3:0] sa, input logic [3:0] sb,
    input logic [3:0] de, input logic [3:0] dm,
    input logic [63:0] va, input logic [63:0] vb
  );
    vec_t v;
    v.icode = ic; v.rA = ra; v.rB = rb; v.valP = vp;
    v.ed = ed; v.mm = mm; v.me = me; v.wm = wm; v.we = we;
    v.x.sa = sa; v.x.sb = sb; v.x.de = de; v.x.dm = dm;
    v.x.va = va; v.x.vb = vb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_fwd();
    e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
  endtask

  task automatic drive(input vec_t v);
    D_icode = v.icode; D_rA = v.rA; D_rB = v.rB; D_valP = v.valP;
    e_dstE = v.ed; M_dstM = v.mm; M_dstE = v.me;
    W_dstM = v.wm; W_dstE = v.we;
    sb_q.push_back(v.x);
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      chk({tag, " sb_empty"}, 64'd1, 64'd0);
      return;
    end
    x = sb_q.pop_front();
    chk({tag, " srcA"}, 64'(d_srcA), 64'(x.sa));
    chk({tag, " srcB"}, 64'(d_srcB), 64'(x.sb));
    chk({tag, " dstE"}, 64'(d_dstE), 64'(x.de));
    chk({tag, " dstM"}, 64'(d_dstM), 64'(x.dm));
    chk({tag, " valA"}, d_valA, x.va);
    chk({tag, " valB"}, d_valB, x.vb);
  endtask

  // One W-stage write committed at the next rising edge.
  task automatic wb(input logic [3:0] de, input logic [63:0] ve,
                    input logic [3:0] dm, input logic [63:0] vm);
    @(negedge clk);
    W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
    @(posedge clk);
    #1;
    W_dstE = F; W_dstM = F;
  endtask

  task automatic dbg(input logic [3:0] a, input logic [63:0] exp,
                     input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    D_icode = 4'h1; D_ifun = 4'h0; D_rA = F; D_rB = F; D_valP = '0;
    idle_fwd();
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    dbg_addr = 4'h0;
    repeat (2) @(posedge clk);

    // Reset must win over a concurrent write-back.
    @(negedge clk);
    W_dstE = 4'h3; W_valE = 64'h55;
    @(posedge clk);
    #1;
    reset = 1'b0;
    W_dstE = F;
    for (int i = 0; i < 16; i++)
      dbg(4'(i), 64'd0, $sformatf("reset_r%0d", i));

    wb(4'h2, 64'h1234, F, 64'h0);
    wb(4'h1, 64'h10, F, 64'h0);
    dbg(4'h2, 64'h1234, "wr_r2");
    dbg(4'h1, 64'h10, "wr_r1");
    dbg(4'h3, 64'h0, "r3_clean");

    // Table vectors; forwarding values fixed per stage.
    vecs.push_back(mk(4'h2, 4'h2, 4'h5, 0, F, F, F, F, F,
                      4'h2, F, 4'h5, F, 64'h1234, 64'h0));
    vecs.push_back(mk(4'h6, 4'h1, 4'h7, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1,
                      4'h1, 4'h7, 4'h7, F, 64'h11, 64'h0));
    vecs.push_back(mk(4'h6, 4'h1, 4'h7, 0, F, 4'h1, 4'h1, 4'h1, 4'h1,
                      4'h1, 4'h7, 4'h7, F, 64'h22, 64'h0));
    vecs.push_back(mk(4'h6, 4'h1, 4'h7, 0, F, F, 4'h1, 4'h1, 4'h1,
                      4'h1, 4'h7, 4'h7, F, 64'h33, 64'h0));
    vecs.push_back(mk(4'h6, 4'h1, 4'h7, 0, F, F, F, 4'h1, 4'h1,
                      4'h1, 4'h7, 4'h7, F, 64'h44, 64'h0));
    vecs.push_back(mk(4'h6, 4'h1, 4'h7, 0, F, F, F, F, 4'h1,
                      4'h1, 4'h7, 4'h7, F, 64'h55, 64'h0));
    vecs.push_back(mk(4'h6, 4'h1, 4'h7, 0, F, F, F, F, F,
                      4'h1, 4'h7, 4'h7, F, 64'h10, 64'h0));
    vecs.push_back(mk(4'h8, F, F, 64'h40, 4'h4, F, F, F, F,
                      F, 4'h4, 4'h4, F, 64'h40, 64'h11));
    vecs.push_back(mk(4'hx, F, F, 64'h99, F, F, F, F, F,
                      F, F, F, F, 64'h0, 64'h0));
    vecs.push_back(mk(4'h0, F, F, 64'h99, F, F, F, F, F,
                      F, F, F, F, 64'h0, 64'h0));
    vecs.push_back(mk(4'hB, 4'h3, F, 0, F, F, 4'h4, F, F,
                      4'h4, 4'h4, 4'h4, 4'h3, 64'h33, 64'h33));
    vecs.push_back(mk(4'h5, 4'h6, 4'h1, 0, F, F, F, F, F,
                      F, 4'h1, F, 4'h6, 64'h0, 64'h10));
    vecs.push_back(mk(4'h7, F, F, 64'h88, F, F, F, F, F,
                      F, F, F, F, 64'h88, 64'h0));
    vecs.push_back(mk(4'hA, 4'h2, F, 0, F, F, F, F, F,
                      4'h2, 4'h4, 4'h4, F, 64'h1234, 64'h0));
    vecs.push_back(mk(4'h3, F, 4'h5, 0, F, F, F, F, F,
                      F, F, 4'h5, F, 64'h0, 64'h0));
    vecs.push_back(mk(4'h4, 4'h1, 4'h2, 0, F, 4'h2, F, F, F,
                      4'h1, 4'h2, F, F, 64'h10, 64'h22));
    vecs.push_back(mk(4'h9, F, F, 0, F, F, F, 4'h4, F,
                      4'h4, 4'h4, 4'h4, F, 64'h44, 64'h44));

    foreach (vecs[i]) begin
      @(negedge clk);
      e_valE = 64'h11; m_valM = 64'h22; M_valE = 64'h33;
      W_valM = 64'h44; W_valE = 64'h55;
      drive(vecs[i]);
      #2;
      check_out($sformatf("vec%0d", i));
      idle_fwd();
    end
    dbg(4'h1, 64'h10, "r1_untouched");

    // popq %rsp: forwarded from W before the edge, M value wins after.
    @(negedge clk);
    D_icode = 4'h6; D_rA = 4'h4; D_rB = 4'h4;
    W_dstE = 4'h4; W_valE = 64'h100;
    W_dstM = 4'h4; W_valM = 64'h200;
    #1;
    chk("popsp_fwdA", d_valA, 64'h200);
    chk("popsp_fwdB", d_valB, 64'h200);
    @(posedge clk);
    #1;
    W_dstE = F; W_dstM = F;
    dbg(4'h4, 64'h200, "popsp_r4");
    #1;
    chk("popsp_rfA", d_valA, 64'h200);

    // Distinct E and M destinations in one edge.
    wb(4'h5, 64'hABC, 4'hE, 64'hDEF);
    dbg(4'h5, 64'hABC, "dual_r5");
    dbg(4'hE, 64'hDEF, "dual_r14");
    dbg(4'hF, 64'h0, "dbg_F");

    // Reset clears previously written state.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dbg(4'h4, 64'h0, "rst2_r4");
    dbg(4'hE, 64'h0, "rst2_r14");

    if (sb_q.size() != 0)
      chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_writeback.md
# decode_writeback

Decode and write-back stage of the Y86-64 pipeline, directly downstream of the decode pipeline register. It decodes `D_icode`, `D_rA` and `D_rB` into source and destination register IDs. It reads the 15-entry, 64-bit register file and resolves data hazards by forwarding from the E, M and W stages, producing `d_valA`/`d_valB` for the execute pipeline register. The same block owns the register file and commits W-stage results at the clock edge.

## Interface
Parameters:
- `RNONE`, 4'hF, "no register" ID
- `RRSP`, 4'h4, stack pointer ID

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous reset, active-high
- `D_icode`, `D_ifun`, `D_rA`, `D_rB`  in  4 each  decode register outputs
- `D_valP`  in  64  incremented PC
- `e_dstE`, `e_valE`  in  4/64  execute-stage destination (after cmov condition) and result
- `M_dstE`, `M_valE`  in  4/64  memory-register E destination and value
- `M_dstM`, `m_valM`  in  4/64  memory-register M destination and memory read data
- `W_dstE`, `W_valE`, `W_dstM`, `W_valM`  in  4/64  write-back register fields
- `d_srcA`, `d_srcB`, `d_dstE`, `d_dstM`  out  4 each  decoded register IDs
- `d_valA`, `d_valB`  out  64  operand values after forwarding
- `dbg_addr`  in  4  debug read address
- `dbg_data`  out  64  register file contents at `dbg_addr`; 0 for 4'hF

## Operation
ID decode is combinational, by `D_icode`. Any icode not listed below, including X from a bubbled decode register, yields `RNONE`.
- `d_srcA`:
  - `D_rA` for icode 2, 4, 6, A
  - `RRSP` for 9, B
- `d_srcB`:
  - `D_rB` for 4, 5, 6
  - `RRSP` for 8, 9, A, B
- `d_dstE`:
  - `D_rB` for 2, 3, 6
  - `RRSP` for 8, 9, A, B
- `d_dstM`: `D_rA` for 5, B

`d_valA` selection, first match wins:
1. icode 7 or 8 → `D_valP`.
2. `d_srcA == e_dstE` → `e_valE`.
3. `== M_dstM` → `m_valM`.
4. `== M_dstE` → `M_valE`.
5. `== W_dstM` → `W_valM`.
6. `== W_dstE` → `W_valE`.
7. Otherwise → `regfile[d_srcA]`.

`d_valB` uses the same chain without step 1, keyed on `d_srcB`.

Matching rules:
- `d_srcX == RNONE` never matches a forwarding source. Result is 0.
- Any forwarding destination equal to `RNONE` never matches.

Register file:
- 15 entries × 64 bits, indices 0–14. Index F is not storage; reads of it return 0.

Write-back, rising edge, `reset` low:
- `W_dstE != RNONE` → `regfile[W_dstE] <= W_valE`.
- `W_dstM != RNONE` → `regfile[W_dstM] <= W_valM`.
- `W_dstE == W_dstM != RNONE` → `W_valM` wins (popq %rsp semantics).

Reset:
- `reset` high at an edge → all 15 entries <= 0.
- Reset overrides any concurrent write-back.
- No other state exists.

## Timing
- All outputs are combinational from inputs and register file state. No added latency.
- A write commits at edge N and is visible to reads after edge N.
- During the cycle before edge N, the value is supplied via the W forwarding path. No internal write-before-read bypass is needed.
- After reset is released, every register reads 0 until written.
- `d_valA`, `d_valB` and `dbg_data` after reset: 0 unless forwarded or `D_valP`-selected.
- Stall and bubble are handled by the surrounding pipeline registers. This block has no enable.

## Test plan
- Reset, then `dbg_addr` sweep 0..F → `dbg_data` = 0 for all. Assert reset while W writes 0x55 to r3 → r3 stays 0.
- W_dstE=2, W_valE=0x1234 for one edge. Next cycle, D=rrmovq (icode 2) with rA=2 → `d_srcA`=2, `d_valA`=0x1234 from the regfile, `d_dstE`=`D_rB`.
- Priority: r1 = 0x10 in the regfile. e_dstE=1/0x11, M_dstM=1/0x22, M_dstE=1/0x33, W_dstM=1/0x44, W_dstE=1/0x55. OPq rA=1 → 0x11. Remove sources one at a time → 0x22, 0x33, 0x44, 0x55, then 0x10.
- call (icode 8), D_valP=0x40 with e_dstE=4 → `d_valA`=0x40, `d_srcB`=4, `d_valB`=`e_valE`, `d_dstE`=4, `d_dstM`=F.
- popq %rsp at W: W_dstE=4/0x100, W_dstM=4/0x200 → r4=0x200 after the edge.
- `D_icode`=X (bubble), rA=rB=F → all IDs F, `d_valA`=`d_valB`=0, even with every forwarding destination set to F.
